em_readout: RTL and testbench
=============================

Name: em_readout

Overview:
- Downstream consumer of the error processor's latched error-monitor flags (EM1N..EM26N) and group summaries (EMRG1..EMRG4).
- On a read request, snapshots all 26 flag positions into a shadow word and serialises it to the LVDC data path as a 26-bit word plus an odd-parity bit.
- Raises a sticky error interrupt whenever any summary group reports an error.

Parameters:
- BIT_DIV, 4: SIM_CLK cycles per serial bit period; must be >= 2.
- WORD_BITS, 26: data bits per word, matching the LVDC data word.

Ports:
- SIM_CLK  in  1  system clock.
- SIM_RST  in  1  reset, asynchronous, active-low.
- EMN      in  26  active-low latched error flags; EMN[k-1] = EMkN. Integrator ties EMN[12] and EMN[13] (EM13N/EM14N, not exported by the error processor) high.
- EMRG     in  4  group summaries; EMRG[g-1] = EMRGg; high = group has an error.
- RD_REQ   in  1  read request; level, rising-edge triggered.
- INT_CLR  in  1  one-cycle clear for ERR_INT.
- RD_BUSY  out  1  high from the capture cycle through the done cycle.
- SER_DATA out  1  serial data; held for a full bit period.
- SER_STB  out  1  one-cycle strobe on the last cycle of each bit period.
- SER_END  out  1  one-cycle pulse coincident with the parity-bit strobe.
- ERR_INT  out  1  sticky error interrupt.

Behaviour:
- Reset (SIM_RST low, asynchronous): state IDLE; all outputs 0; shadow, counters and the RD_REQ edge register cleared. Assertion mid-word aborts immediately with no SER_END. After release, the next rising edge of RD_REQ is serviced normally.
- States: IDLE -> CAPTURE -> SHIFT -> PARITY -> DONE -> IDLE.
- IDLE: a registered edge detector sees RD_REQ 0 then 1; the next cycle is CAPTURE. RD_REQ held high does not retrigger until it has been seen low.
- CAPTURE (1 cycle, RD_BUSY=1):
  - shadow <= ~EMN with bits 12 and 13 forced 0 (reserved mask).
  - Parity register <= odd parity of the masked word: XNOR-reduce, so total ones including parity is odd.
- SHIFT: bit counter 0..25, LSB first (EM1 first). Divider counts 0..BIT_DIV-1. SER_DATA = shadow[bit] for the whole period; SER_STB=1 when divider = BIT_DIV-1. After bit 25's strobe, go to PARITY.
- PARITY: one bit period carrying the parity bit. SER_STB and SER_END are both asserted on its last cycle.
- DONE (1 cycle): SER_DATA=0, RD_BUSY still 1; then IDLE with RD_BUSY=0.
- Latency and length:
  - RD_REQ rise seen at edge n -> CAPTURE in cycle n+1.
  - First data bit from n+2.
  - RD_BUSY high for 1 + 27*BIT_DIV + 1 cycles.
  - Exactly 27 SER_STB pulses per word.
- RD_REQ rises while busy: ignored, not queued.
- EMN changes after CAPTURE do not alter the word in flight.
- SER_DATA = 0 whenever not in SHIFT/PARITY.
- ERR_INT:
  - Set on the cycle after OR(EMRG) is sampled 1 while the previous sample was 0 (rising edge).
  - Cleared by INT_CLR.
  - Simultaneous set and clear: set wins.
  - OR(EMRG) staying high does not re-set ERR_INT after a clear.
- Divider width is clog2(BIT_DIV). The bit counter is 5 bits and never wraps past 25.

Decomposition:
- Shared package em_pkg:
  - WORD_BITS constant.
  - Reserved-bit mask 26'h0003000.
  - State enum {IDLE, CAPTURE, SHIFT, PARITY, DONE}.
- One natural sub-module, em_serializer: bit divider, bit counter, data and parity mux, STB/END generation. It is driven by a load pulse and busy handshake from the top-level FSM.

Test Plan:
- Reset: SIM_RST low with random EMN/EMRG -> all outputs 0; release, then idle 20 cycles -> outputs stay 0.
- Word (BIT_DIV=4): EMN all 1 except EM1N=0 and EM26N=0; pulse RD_REQ -> 27 strobes. Bit values at the strobes are 1, 24x 0, 1, then parity 1. SER_END on strobe 27. RD_BUSY high 110 cycles.
- Reserved and full word: EMN = 26'h0 (all errors) -> bits 12 and 13 transmit 0, the other 24 transmit 1, parity = 1.
- Snapshot and retrigger: flip EMN at bit 10 and hold RD_REQ high throughout -> word unchanged, only one word sent. Drop RD_REQ, raise again -> second word reflects the new EMN.
- Interrupt: EMRG 0000 -> 0010 gives ERR_INT=1 the next cycle. INT_CLR alone clears it. INT_CLR coincident with a new 0->1 OR edge leaves ERR_INT=1.
- Reset mid-word: assert SIM_RST during bit 10 -> SER_DATA/STB/BUSY drop immediately, no SER_END. Next RD_REQ sends a complete correct word.

Source files
------------

// File: rtl/em_pkg.sv
// em_pkg: shared constants and state encoding for the error-monitor readout.
package em_pkg;
    localparam int WORD_BITS = 26;
    // EM13N/EM14N are not exported upstream, so their positions always read as no-error
    localparam logic [WORD_BITS-1:0] RSV_MASK = 26'h0003000;
    typedef enum logic [2:0] {IDLE, CAPTURE, SHIFT, PARITY, DONE} state_t;
endpackage

// File: rtl/em_serializer.sv
// em_serializer: bit-period divider, bit counter and data/parity mux for one readout word.
module em_serializer
    import em_pkg::*;
#(
    parameter int BIT_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 shift_en,
    input  logic                 par_en,
    input  logic [WORD_BITS-1:0] word,
    output logic                 ser_data,
    output logic                 ser_stb,
    output logic                 ser_end,
    output logic                 last_bit
);
    localparam int DW = $clog2(BIT_DIV);
    localparam logic [4:0] LAST = 5'(WORD_BITS - 1);
    logic [WORD_BITS-1:0] shadow;
    logic                 par;
    logic [DW-1:0]        div;
    logic [4:0]           bitc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            par    <= 1'b0;
            div    <= '0;
            bitc   <= '0;
        end else if (load) begin
            shadow <= word;
            par    <= ~^word;
            div    <= '0;
            bitc   <= '0;
        end else if (shift_en || par_en) begin
            div <= ser_stb ? '0 : div + 1'b1;
            if (shift_en && ser_stb && bitc != LAST) bitc <= bitc + 1'b1;
        end
    end
    assign ser_stb  = (shift_en || par_en) && div == DW'(BIT_DIV - 1);
    assign ser_data = shift_en ? shadow[bitc] : par_en & par;
    assign ser_end  = par_en & ser_stb;
    assign last_bit = shift_en & ser_stb & (bitc == LAST);
endmodule

// File: rtl/em_readout.sv
// em_readout: snapshots the latched error flags on a read request, sends them serially
// with odd parity, and raises a sticky interrupt on any new group error.
module em_readout
    import em_pkg::*;
#(
    parameter int BIT_DIV = 4
) (
    input  logic                 SIM_CLK,
    input  logic                 SIM_RST,
    input  logic [WORD_BITS-1:0] EMN,
    input  logic [3:0]           EMRG,
    input  logic                 RD_REQ,
    input  logic                 INT_CLR,
    output logic                 RD_BUSY,
    output logic                 SER_DATA,
    output logic                 SER_STB,
    output logic                 SER_END,
    output logic                 ERR_INT
);
    state_t state;
    logic   rd_q;
    logic   or_q;
    logic   last_bit;
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            state   <= IDLE;
            RD_BUSY <= 1'b0;
            rd_q    <= 1'b0;
            or_q    <= 1'b0;
            ERR_INT <= 1'b0;
        end else begin
            rd_q    <= RD_REQ;
            or_q    <= |EMRG;
            // a fresh group error outranks a coincident clear
            ERR_INT <= (|EMRG && !or_q) || (ERR_INT && !INT_CLR);
            case (state)
                IDLE: if (RD_REQ && !rd_q) begin
                    state   <= CAPTURE;
                    RD_BUSY <= 1'b1;
                end
                CAPTURE: state <= SHIFT;
                SHIFT:   if (last_bit) state <= PARITY;
                PARITY:  if (SER_END) state <= DONE;
                DONE: begin
                    state   <= IDLE;
                    RD_BUSY <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
    em_serializer #(.BIT_DIV(BIT_DIV)) u_ser (
        .clk      (SIM_CLK),
        .rst_n    (SIM_RST),
        .load     (state == CAPTURE),
        .shift_en (state == SHIFT),
        .par_en   (state == PARITY),
        .word     (~EMN & ~RSV_MASK),
        .ser_data (SER_DATA),
        .ser_stb  (SER_STB),
        .ser_end  (SER_END),
        .last_bit (last_bit)
    );
endmodule

// File: tb/tb_em_readout.sv
// tb_em_readout: directed checks of word framing, snapshot, retrigger, interrupt and reset.
module tb_em_readout;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [25:0] emn = '1;
    logic [3:0]  emrg = '0;
    logic        rd_req = 1'b0;
    logic        int_clr = 1'b0;
    logic        rd_busy, ser_data, ser_stb, ser_end, err_int;
    int          pass_cnt = 0;
    int          total = 0;

    em_readout #(.BIT_DIV(4)) dut (
        .SIM_CLK (clk),
        .SIM_RST (rst_n),
        .EMN     (emn),
        .EMRG    (emrg),
        .RD_REQ  (rd_req),
        .INT_CLR (int_clr),
        .RD_BUSY (rd_busy),
        .SER_DATA(ser_data),
        .SER_STB (ser_stb),
        .SER_END (ser_end),
        .ERR_INT (err_int)
    );

    always #5 clk = ~clk;

    function automatic logic [26:0] exp_word(input logic [25:0] e);
        logic [25:0] w;
        w = ~e & ~26'h0003000;
        return {~^w, w};
    endfunction

    task automatic run_word(input logic [25:0] flip_val, input int flip_at,
                            output logic [26:0] bits, output int nstb, output int busy,
                            output int end_idx, output int first_busy);
        bit done = 0;
        bits = '0; nstb = 0; busy = 0; end_idx = -1; first_busy = -1;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (rd_busy) begin
                if (first_busy < 0) first_busy = c;
                busy++;
            end
            if (ser_stb) begin
                if (nstb < 27) bits[nstb] = ser_data;
                if (ser_end) end_idx = nstb;
                nstb++;
                if (nstb == flip_at) emn = flip_val;
            end
            if (first_busy >= 0 && !rd_busy) done = 1;
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        emn = 26'($urandom); emrg = 4'($urandom); rd_req = 0; int_clr = 0;
        #12;
        total++;
        if ({rd_busy, ser_data, ser_stb, ser_end, err_int} !== 5'b0)
            $display("FAIL reset_outputs: got %b expected 00000", {rd_busy, ser_data, ser_stb, ser_end, err_int});
        else pass_cnt++;
        emrg = '0;
        @(negedge clk) rst_n = 1;
        repeat (20) begin
            @(negedge clk);
            if ({rd_busy, ser_data, ser_stb, ser_end, err_int} !== 5'b0) bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL idle_outputs: %0d nonzero cycles expected 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_word();
        logic [26:0] bits; int nstb, busy, eidx, fb;
        @(negedge clk) emn = 26'h1FFFFFE; rd_req = 1;
        run_word('0, -1, bits, nstb, busy, eidx, fb);
        rd_req = 0;
        total++; if (bits !== 27'h6000001) $display("FAIL word_bits: got %h expected %h", bits, 27'h6000001); else pass_cnt++;
        total++; if (nstb !== 27) $display("FAIL word_strobes: got %0d expected 27", nstb); else pass_cnt++;
        total++; if (eidx !== 26) $display("FAIL word_end: got %0d expected 26", eidx); else pass_cnt++;
        total++; if (busy !== 110) $display("FAIL word_busy: got %0d expected 110", busy); else pass_cnt++;
        total++; if (fb !== 0) $display("FAIL word_latency: got %0d expected 0", fb); else pass_cnt++;
    endtask

    task automatic test_full_word();
        logic [26:0] bits; int nstb, busy, eidx, fb;
        @(negedge clk) emn = '0; rd_req = 1;
        run_word('0, -1, bits, nstb, busy, eidx, fb);
        rd_req = 0;
        total++; if (bits !== 27'h7FFCFFF) $display("FAIL full_bits: got %h expected %h", bits, 27'h7FFCFFF); else pass_cnt++;
        total++; if (nstb !== 27) $display("FAIL full_strobes: got %0d expected 27", nstb); else pass_cnt++;
    endtask

    task automatic test_snapshot_retrigger();
        logic [26:0] bits; int nstb, busy, eidx, fb;
        int extra = 0;
        @(negedge clk) emn = 26'h15A5A5A; rd_req = 1;
        run_word(26'h0C3C3C3, 10, bits, nstb, busy, eidx, fb);
        total++; if (bits !== exp_word(26'h15A5A5A)) $display("FAIL snap_bits: got %h expected %h", bits, exp_word(26'h15A5A5A)); else pass_cnt++;
        repeat (20) begin
            @(negedge clk);
            if (rd_busy) extra++;
        end
        total++; if (extra !== 0) $display("FAIL no_retrigger: %0d busy cycles expected 0", extra); else pass_cnt++;
        rd_req = 0;
        @(negedge clk) rd_req = 1;
        run_word('0, -1, bits, nstb, busy, eidx, fb);
        rd_req = 0;
        total++; if (bits !== exp_word(26'h0C3C3C3)) $display("FAIL second_bits: got %h expected %h", bits, exp_word(26'h0C3C3C3)); else pass_cnt++;
    endtask

    task automatic test_interrupt();
        @(negedge clk) emrg = 4'b0000;
        @(negedge clk);
        total++; if (err_int !== 1'b0) $display("FAIL int_idle: got %b expected 0", err_int); else pass_cnt++;
        emrg = 4'b0010;
        @(negedge clk);
        total++; if (err_int !== 1'b1) $display("FAIL int_set: got %b expected 1", err_int); else pass_cnt++;
        int_clr = 1;
        @(negedge clk) int_clr = 0;
        total++; if (err_int !== 1'b0) $display("FAIL int_clear: got %b expected 0", err_int); else pass_cnt++;
        repeat (3) @(negedge clk);
        total++; if (err_int !== 1'b0) $display("FAIL int_level_hold: got %b expected 0", err_int); else pass_cnt++;
        emrg = 4'b0000;
        @(negedge clk) emrg = 4'b1000; int_clr = 1;
        @(negedge clk) int_clr = 0;
        total++; if (err_int !== 1'b1) $display("FAIL int_set_wins: got %b expected 1", err_int); else pass_cnt++;
        @(negedge clk) int_clr = 1; emrg = 4'b0000;
        @(negedge clk) int_clr = 0;
    endtask

    task automatic test_reset_midword();
        logic [26:0] bits; int nstb, busy, eidx, fb;
        int n = 0;
        int ends = 0;
        @(negedge clk) emn = '0; rd_req = 1;
        for (int c = 0; c < 200 && n < 10; c++) begin
            @(negedge clk);
            if (ser_stb) n++;
        end
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        total++;
        if ({rd_busy, ser_data, ser_stb, ser_end} !== 4'b0)
            $display("FAIL midword_abort: got %b expected 0000 (strobes seen %0d)", {rd_busy, ser_data, ser_stb, ser_end}, n);
        else pass_cnt++;
        repeat (3) begin
            @(negedge clk);
            if (ser_end) ends++;
        end
        rd_req = 0;
        @(negedge clk) rst_n = 1;
        repeat (3) begin
            @(negedge clk);
            if (ser_end || rd_busy) ends++;
        end
        total++; if (ends !== 0) $display("FAIL midword_no_end: got %0d expected 0", ends); else pass_cnt++;
        rd_req = 1;
        run_word('0, -1, bits, nstb, busy, eidx, fb);
        rd_req = 0;
        total++; if (bits !== 27'h7FFCFFF) $display("FAIL after_reset_bits: got %h expected %h", bits, 27'h7FFCFFF); else pass_cnt++;
        total++; if (busy !== 110) $display("FAIL after_reset_busy: got %0d expected 110", busy); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_word();
        test_full_word();
        test_snapshot_retrigger();
        test_interrupt();
        test_reset_midword();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
